// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/timer display path.
package stopwatch_pkg;

    localparam int              WIDTH        = 39;
    localparam logic [WIDTH-1:0] MAX_MS       = 39'd3_599_999;
    localparam logic [7:0]      DECS_DEFAULT = 8'b00101000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stopwatch_controller.sv
// Millisecond stopwatch / countdown timer controller feeding the seven-segment display path.
// Advances on the ms_tick enable; handles start/stop, lap freeze and clear.
module stopwatch_controller
    import stopwatch_pkg::*;
(
    input  logic             clock,
    input  logic             rst_n,
    input  logic             ms_tick,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    input  logic             mode,
    input  logic [WIDTH-1:0] time_in,
    output logic [WIDTH-1:0] count_out,
    output logic [7:0]       decs,
    output logic             running,
    output logic             lap_frozen,
    output logic             done,
    output logic             alarm
);

    state_t           state, state_n;
    logic [WIDTH-1:0] elapsed, elapsed_n;
    logic [WIDTH-1:0] lap_reg, lap_reg_n;
    logic [WIDTH-1:0] preset;
    logic             mode_q, mode_q_n;
    logic             frozen_n, alarm_n;

    assign preset = mode ? ((time_in > MAX_MS) ? MAX_MS : time_in) : '0;

    // Reaching the terminal count wins over a simultaneous start_stop, so a
    // finished run always lands in DONE rather than a paused terminal value.
    always_comb begin
        state_n   = state;
        elapsed_n = elapsed;
        lap_reg_n = lap_reg;
        mode_q_n  = mode_q;
        frozen_n  = lap_frozen;
        alarm_n   = 1'b0;

        if (clear) begin
            state_n   = IDLE;
            elapsed_n = '0;
            frozen_n  = 1'b0;
        end else begin
            if (lap) begin
                if (lap_frozen) begin
                    frozen_n = 1'b0;
                end else if (state == RUN) begin
                    lap_reg_n = elapsed;
                    frozen_n  = 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    elapsed_n = preset;
                    if (start_stop && !(mode && preset == '0)) begin
                        state_n  = RUN;
                        mode_q_n = mode;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state_n = PAUSE;
                    end
                    if (ms_tick) begin
                        if (!mode_q && elapsed != MAX_MS) begin
                            elapsed_n = elapsed + 1'b1;
                            if (elapsed == MAX_MS - 1'b1) begin
                                state_n = DONE;
                                alarm_n = 1'b1;
                            end
                        end else if (mode_q && elapsed != '0) begin
                            elapsed_n = elapsed - 1'b1;
                            if (elapsed == WIDTH'(1)) begin
                                state_n = DONE;
                                alarm_n = 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_n = RUN;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            elapsed    <= '0;
            lap_reg    <= '0;
            mode_q     <= 1'b0;
            lap_frozen <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_n;
            elapsed    <= elapsed_n;
            lap_reg    <= lap_reg_n;
            mode_q     <= mode_q_n;
            lap_frozen <= frozen_n;
            alarm      <= alarm_n;
        end
    end

    assign count_out = lap_frozen ? lap_reg : elapsed;
    assign decs      = DECS_DEFAULT | {7'b0, lap_frozen};
    assign running   = (state == RUN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_stopwatch_controller.sv
// Randomized and directed bench for stopwatch_controller against a behavioural model.
module tb_stopwatch_controller;
    import stopwatch_pkg::*;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             ms_tick = 1'b0;
    logic             start_stop = 1'b0;
    logic             lap = 1'b0;
    logic             clear = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] time_in = '0;
    logic [WIDTH-1:0] count_out;
    logic [7:0]       decs;
    logic             running, lap_frozen, done, alarm;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 counting, 2 paused, 3 finished.
    int      m_phase  = 0;
    longint  m_time   = 0;
    longint  m_lapval = 0;
    bit      m_frozen = 0;
    bit      m_down   = 0;
    bit      m_alarm  = 0;
    longint  max_ms   = 3599999;

    stopwatch_controller dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .ms_tick    (ms_tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .mode       (mode),
        .time_in    (time_in),
        .count_out  (count_out),
        .decs       (decs),
        .running    (running),
        .lap_frozen (lap_frozen),
        .done       (done),
        .alarm      (alarm)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint presetNow();
        longint t;
        t = longint'(time_in);
        if (!mode) return 0;
        return (t > max_ms) ? max_ms : t;
    endfunction

    task automatic modelReset();
        m_phase = 0; m_time = 0; m_lapval = 0; m_frozen = 0; m_down = 0; m_alarm = 0;
    endtask

    task automatic modelStep(input bit ss, input bit lp, input bit cl, input bit tk);
        m_alarm = 0;
        if (cl) begin
            m_phase = 0; m_time = 0; m_frozen = 0;
            return;
        end
        if (lp) begin
            if (m_frozen) m_frozen = 0;
            else if (m_phase == 1) begin m_lapval = m_time; m_frozen = 1; end
        end
        if (m_phase == 0) begin
            m_time = presetNow();
            if (ss && !(mode && m_time == 0)) begin m_down = mode; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (ss) m_phase = 2;
            if (tk) begin
                if (!m_down && m_time < max_ms) begin
                    m_time++;
                    if (m_time == max_ms) begin m_phase = 3; m_alarm = 1; end
                end else if (m_down && m_time > 0) begin
                    m_time--;
                    if (m_time == 0) begin m_phase = 3; m_alarm = 1; end
                end
            end
        end else if (m_phase == 2) begin
            if (ss) m_phase = 1;
        end
    endtask

    task automatic checkAll(input string ctx);
        checkOutput({ctx, "_count"},  64'(count_out),  64'(m_frozen ? m_lapval : m_time));
        checkOutput({ctx, "_decs"},   64'(decs),       64'(8'h28 | {7'b0, m_frozen}));
        checkOutput({ctx, "_running"},64'(running),    64'(m_phase == 1));
        checkOutput({ctx, "_done"},   64'(done),       64'(m_phase == 3));
        checkOutput({ctx, "_frozen"}, 64'(lap_frozen), 64'(m_frozen));
        checkOutput({ctx, "_alarm"},  64'(alarm),      64'(m_alarm));
    endtask

    task automatic applyStimulus(input bit ss, input bit lp, input bit cl, input bit tk, input string ctx);
        start_stop = ss; lap = lp; clear = cl; ms_tick = tk;
        @(posedge clock);
        modelStep(ss, lp, cl, tk);
        #1;
        start_stop = 0; lap = 0; clear = 0; ms_tick = 0;
        checkAll(ctx);
    endtask

    task automatic tickN(input int n, input string ctx);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, ctx);
    endtask

    initial begin
        #12;
        checkAll("reset");
        rst_n = 1'b1;
        @(posedge clock); #1;

        // Up count, stop, paused ticks ignored
        mode = 0;
        applyStimulus(1, 0, 0, 0, "up_start");
        tickN(5000, "up_run");
        applyStimulus(1, 0, 0, 0, "up_stop");
        checkOutput("up_5000", 64'(count_out), 64'd5000);
        tickN(10, "up_paused");
        applyStimulus(0, 0, 1, 0, "up_clear");

        // Async reset in the middle of a count
        applyStimulus(1, 0, 0, 0, "rst_start");
        tickN(1234, "rst_run");
        checkOutput("rst_1234", 64'(count_out), 64'd1234);
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        @(negedge clock);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, "after_reset");

        // Down timer from 3
        mode = 1; time_in = 39'd3;
        applyStimulus(0, 0, 0, 0, "dn_idle");
        applyStimulus(1, 0, 0, 0, "dn_start");
        tickN(3, "dn_tick");
        checkOutput("dn_done", 64'(done), 64'd1);
        tickN(2, "dn_hold");
        applyStimulus(0, 0, 1, 0, "dn_clear");
        time_in = '0;
        applyStimulus(1, 0, 0, 0, "dn_zero_ign");
        checkOutput("dn_zero_run", 64'(running), 64'd0);
        time_in = {39{1'b1}};
        applyStimulus(0, 0, 0, 0, "dn_sat");
        checkOutput("dn_sat_max", 64'(count_out), 64'(max_ms));

        // Lap freeze and release
        mode = 0;
        applyStimulus(0, 0, 1, 0, "lap_clear");
        applyStimulus(1, 0, 0, 0, "lap_start");
        tickN(100, "lap_run");
        applyStimulus(0, 1, 0, 1, "lap_take");
        checkOutput("lap_100", 64'(count_out), 64'd100);
        tickN(49, "lap_frozen_run");
        applyStimulus(0, 1, 0, 0, "lap_release");
        checkOutput("lap_150", 64'(count_out), 64'd150);

        // Clear beats start_stop and tick
        applyStimulus(0, 1, 0, 0, "clr_lap");
        applyStimulus(1, 0, 1, 1, "clr_combo");
        checkOutput("clr_zero", 64'(count_out), 64'd0);

        // Up terminal count with preloaded elapsed
        applyStimulus(1, 0, 0, 0, "max_start");
        applyStimulus(1, 0, 0, 0, "max_pause");
        m_time = max_ms - 3;
        force dut.elapsed = MAX_MS - 39'd3;
        @(posedge clock); #1;
        release dut.elapsed;
        checkAll("max_forced");
        applyStimulus(1, 0, 0, 0, "max_resume");
        tickN(3, "max_tick");
        checkOutput("max_value", 64'(count_out), 64'(max_ms));
        tickN(2, "max_nowrap");
        applyStimulus(0, 0, 1, 0, "max_clear");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit ss, lp, cl, tk;
            if (m_phase == 0 && $urandom_range(7) == 0) begin
                mode = 1'($urandom_range(1));
                time_in = ($urandom_range(3) == 0) ? {7'($urandom), $urandom} : 39'($urandom_range(30));
            end
            ss = ($urandom_range(14) == 0);
            lp = ($urandom_range(24) == 0);
            cl = ($urandom_range(79) == 0);
            tk = ($urandom_range(1) == 0);
            if (m_phase == 1 && tk && ((!m_down && m_time == max_ms - 1) || (m_down && m_time == 1)))
                ss = 0;
            applyStimulus(ss, lp, cl, tk, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for the stopwatch/timer display path. It owns the millisecond time register, runs it as an up-counting stopwatch or a down-counting timer, and handles start/stop, lap-freeze and clear commands. Its outputs are the value and decimal-point mask handed to `seven_seg_fsm`. It advances on a single-cycle `ms_tick` enable in the system clock domain; it is never clocked by a divided clock.

## Interface
- `WIDTH`, 39, width of the time value in ms (matches the display datapath).
- `MAX_MS`, 3_599_999, terminal count for up mode (59:59.999).
- `DECS_DEFAULT`, 8'b00101000, base decimal-point mask.
- `clock`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ms_tick`  in  1  one-cycle pulse, once per ms, synchronous to `clock`.
- `start_stop`  in  1  debounced one-cycle command pulse.
- `lap`  in  1  debounced one-cycle command pulse.
- `clear`  in  1  debounced one-cycle command pulse.
- `mode`  in  1  0 = stopwatch (up), 1 = timer (down); sampled only in IDLE.
- `time_in`  in  WIDTH  timer preset in ms; values above `MAX_MS` are saturated to `MAX_MS`.
- `count_out`  out  WIDTH  value to display.
- `decs`  out  8  decimal-point mask.
- `running`  out  1  high while in RUN.
- `lap_frozen`  out  1  display is frozen on the lap value.
- `done`  out  1  high while in DONE.
- `alarm`  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset, async on `rst_n` low: IDLE; `elapsed`=0, `lap_reg`=0, `mode_q`=0; outputs `count_out`=0, `running`/`lap_frozen`/`done`/`alarm`=0, `decs`=`DECS_DEFAULT`.
- IDLE:
  - Every cycle, `elapsed` loads 0 if `mode`=0, or `min(time_in, MAX_MS)` if `mode`=1.
  - `start_stop`: latch `mode` into `mode_q`, go to RUN.
  - Exception: if `mode`=1 and the loaded preset is 0, `start_stop` is ignored and the block stays in IDLE.
- RUN, on `ms_tick`:
  - Up (`mode_q`=0): `elapsed`+1. If the result equals `MAX_MS`, go to DONE on the same edge.
  - Down (`mode_q`=1): `elapsed`-1. If the result is 0, go to DONE on the same edge.
  - No wrap-around in either direction.
- RUN, `start_stop`: go to PAUSE. A tick in the same cycle is still counted.
- PAUSE: ticks ignored; `start_stop` returns to RUN.
- DONE: `elapsed` holds its terminal value; ticks and `start_stop` are ignored.
- `clear`, in any state: go to IDLE, release lap freeze, drop any simultaneous tick.
- Command priority in one cycle: `clear` > `start_stop` > `ms_tick`. `lap` is independent of the other three.
- `lap`:
  - When not frozen: valid in RUN only. Captures the pre-tick `elapsed` into `lap_reg` and sets `lap_frozen`; ignored in other states.
  - When frozen: any `lap` clears `lap_frozen`, in any state.
  - `elapsed` keeps counting while the display is frozen.
- Output assignments:
  - `count_out` = `lap_frozen` ? `lap_reg` : `elapsed`.
  - `decs` = `DECS_DEFAULT` | {7'b0, `lap_frozen`}.
  - `running` = (state==RUN); `done` = (state==DONE).
  - `alarm` is high only in the first cycle after entry to DONE.

## Timing
- All state and output registers update on `posedge clock`. No combinational path from any input to any output.
- Command or tick sampled at edge N → effect visible on outputs after edge N (1-cycle latency).
- First count happens on the first `ms_tick` sampled after the edge that entered RUN.
- Back-to-back commands on consecutive cycles are each honoured.
- `rst_n` asserted mid-count clears immediately; release is synchronised at the top level, not in this block.

## Structure
- Package `stopwatch_pkg` holds the state typedef (2-bit enum: IDLE, RUN, PAUSE, DONE), `WIDTH`, `MAX_MS` and `DECS_DEFAULT`.
- Controller is flat: one FSM plus the `elapsed`/`lap_reg` datapath.
- Natural companion sub-module: `ms_tick_gen` (clock → 1-per-ms pulse). It is instantiated beside this block at the top level and replaces clock-divider clocking of the counter.

## Test plan
- Reset mid-RUN at `elapsed`=1234 → all outputs 0 and `decs`=8'b00101000 immediately; state IDLE after release.
- Up mode: start, 5000 ticks, stop → `count_out`=5000, `running`=0; further ticks leave the value at 5000.
- Up mode preloaded near `MAX_MS` (via forced `elapsed`) → reaches 3_599_999, `done`=1, `alarm` high exactly 1 cycle, no wrap on the next tick.
- Down mode, `time_in`=3, start, 3 ticks → `count_out` 2,1,0, DONE on the third tick; with `time_in`=0, `start_stop` is ignored.
- Lap at 100 with a tick in the same cycle → `count_out` stays 100 and `decs` bit0=1; after 50 ticks `lap` → `count_out`=150.
- `clear`+`start_stop`+`ms_tick` in one cycle during RUN → IDLE, `elapsed`=0, `running`=0, `lap_frozen`=0.
